multicycle_main_control: RTL and testbench

//  Main control FSM of the multi-cycle core; sits directly upstream of the ALU control unit.

---
 rtl/multicycle_pkg.sv | 50 +++++
 rtl/branch_cond_eval.sv | 25 ++
 rtl/multicycle_main_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_main_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle core main control and the ALU control unit.
package multicycle_pkg;

  // Opcode field values (instr[15:12]); 0110 and 1101-1111 are undefined.
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SUBI = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0111;
  localparam logic [3:0] OP_SW   = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1011;
  localparam logic [3:0] OP_BGT  = 4'b1100;

  // ALUOp codes understood by the ALU control unit.
  localparam logic [3:0] ALUOP_NONE = 4'b0000;
  localparam logic [3:0] ALUOP_ADD  = 4'b0001;

  // ALU operand B select.
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_STEP   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  // PC source select.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Control states; encodings 1101-1111 are unreachable.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_ALU_WB_R = 4'd4,
    S_EXEC_I   = 4'd5,
    S_ALU_WB_I = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch resolution: decides whether a conditional branch is taken from the ALU flags.
module branch_cond_eval
  import multicycle_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_neg,
  output logic                take
);

  // Condition select by branch opcode; non-branch opcodes never take.
  always_comb begin
    take = 1'b0;
    case (opcode)
      OPCODE_W'(OP_BEQ): take = alu_zero;
      OPCODE_W'(OP_BNE): take = !alu_zero;
      OPCODE_W'(OP_BLT): take = alu_neg;
      OPCODE_W'(OP_BGT): take = !alu_neg && !alu_zero;
      default:           take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle core: one control state per clock,
// memory-ready stalls in FETCH/MEM_RD/MEM_WR, flag-resolved branches.
module multicycle_main_control
  import multicycle_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_neg,
  input  logic                mem_ready,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_source,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal_op
);

  state_t state, next_state;
  logic   take;

  branch_cond_eval #(.OPCODE_W(OPCODE_W)) u_branch_cond_eval (
    .opcode   (opcode),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .take     (take)
  );

  // State register; reset forces IDLE immediately so every strobe drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and output decode; everything defaults to 0 (IDLE/unreachable behaviour).
  always_comb begin
    next_state = state;
    alu_op     = ALUOP_W'(ALUOP_NONE);
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_SRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        alu_op    = ALUOP_W'(ALUOP_ADD);
        alu_src_b = SRC_B_STEP;
        mem_read  = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_op    = ALUOP_W'(ALUOP_ADD);
        alu_src_b = SRC_B_IMM_SH;
        case (opcode)
          OPCODE_W'(OP_R):    next_state = S_EXEC_R;
          OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
          OPCODE_W'(OP_ORI),  OPCODE_W'(OP_SUBI): next_state = S_EXEC_I;
          OPCODE_W'(OP_LW),   OPCODE_W'(OP_SW):   next_state = S_MEM_ADDR;
          OPCODE_W'(OP_BEQ),  OPCODE_W'(OP_BNE),
          OPCODE_W'(OP_BLT),  OPCODE_W'(OP_BGT):  next_state = S_BRANCH;
          OPCODE_W'(OP_J):    next_state = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_op     = ALUOP_W'(opcode);
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_REG;
        next_state = S_ALU_WB_R;
      end
      S_ALU_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_I: begin
        alu_op     = ALUOP_W'(opcode);
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        next_state = S_ALU_WB_I;
      end
      S_ALU_WB_I: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_op     = ALUOP_W'(ALUOP_ADD);
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        next_state = (opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = ALUOP_W'(opcode);
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_REG;
        pc_source  = PC_SRC_ALUOUT;
        pc_write   = take;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: stimulus pushes the expected
// per-cycle control vector, a monitor pops and compares on the falling edge.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       alu_zero, alu_neg, mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_source;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;

  typedef logic [17:0] vec_t;

  vec_t        exp_q[$];
  string       name_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multicycle_main_control #(.OPCODE_W(4), .ALUOP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op)
  );

  // Vector layout: alu_op,src_a,src_b,i_or_d,mem_read,mem_write,ir_write,pc_write,pc_source,reg_write,reg_dst,mem_to_reg,illegal_op
  function automatic vec_t mk(input logic [3:0] aop, input logic sa, input logic [1:0] sb,
                              input logic iord, input logic mr, input logic mw,
                              input logic irw, input logic pcw, input logic [1:0] pcs,
                              input logic rw, input logic rd, input logic m2r, input logic ill);
    return {aop, sa, sb, iord, mr, mw, irw, pcw, pcs, rw, rd, m2r, ill};
  endfunction

  // Hand-derived expected vectors for each control state.
  function automatic vec_t v_zero();                         return '0; endfunction
  function automatic vec_t v_fetch(input logic rdy);         return mk(4'b0001,0,2'b01,0,1,0,rdy,rdy,2'b00,0,0,0,0); endfunction
  function automatic vec_t v_decode(input logic ill);        return mk(4'b0001,0,2'b11,0,0,0,0,0,2'b00,0,0,0,ill); endfunction
  function automatic vec_t v_exec_r(input logic [3:0] op);   return mk(op,1,2'b00,0,0,0,0,0,2'b00,0,0,0,0); endfunction
  function automatic vec_t v_wb_r();                         return mk(4'b0000,0,2'b00,0,0,0,0,0,2'b00,1,1,0,0); endfunction
  function automatic vec_t v_exec_i(input logic [3:0] aop);  return mk(aop,1,2'b10,0,0,0,0,0,2'b00,0,0,0,0); endfunction
  function automatic vec_t v_wb_i();                         return mk(4'b0000,0,2'b00,0,0,0,0,0,2'b00,1,0,0,0); endfunction
  function automatic vec_t v_mem_addr();                     return mk(4'b0001,1,2'b10,0,0,0,0,0,2'b00,0,0,0,0); endfunction
  function automatic vec_t v_mem_rd();                       return mk(4'b0000,0,2'b00,1,1,0,0,0,2'b00,0,0,0,0); endfunction
  function automatic vec_t v_mem_wr();                       return mk(4'b0000,0,2'b00,1,0,1,0,0,2'b00,0,0,0,0); endfunction
  function automatic vec_t v_mem_wb();                       return mk(4'b0000,0,2'b00,0,0,0,0,0,2'b00,1,0,1,0); endfunction
  function automatic vec_t v_branch(input logic [3:0] op, input logic pcw);
    return mk(op,1,2'b00,0,0,0,0,pcw,2'b01,0,0,0,0);
  endfunction
  function automatic vec_t v_jump();                         return mk(4'b0000,0,2'b00,0,0,0,0,1,2'b10,0,0,0,0); endfunction

  // One clock of stimulus: drive inputs after the edge, queue what the DUT must show this cycle.
  task automatic cyc(input logic r, input logic [3:0] op, input logic z, input logic n,
                     input logic rdy, input vec_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n     = r;
    opcode    = op;
    alu_zero  = z;
    alu_neg   = n;
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch_decode(input logic [3:0] op, input string nm);
    cyc(1, op, 0, 0, 1, v_fetch(1), {nm, "_fetch"});
    cyc(1, op, 0, 0, 1, v_decode(0), {nm, "_decode"});
  endtask

  task automatic alu_i(input logic [3:0] op, input string nm);
    fetch_decode(op, nm);
    cyc(1, op, 0, 0, 1, v_exec_i(op), {nm, "_exec_i"});
    cyc(1, op, 0, 0, 1, v_wb_i(), {nm, "_wb_i"});
  endtask

  task automatic br(input logic [3:0] op, input logic z, input logic n, input logic pcw, input string nm);
    fetch_decode(op, nm);
    cyc(1, op, z, n, 1, v_branch(op, pcw), {nm, "_branch"});
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued expectation.
  initial begin
    vec_t  e;
    vec_t  act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
               pc_write, pc_source, reg_write, reg_dst, mem_to_reg, illegal_op};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b", nm, act, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = 4'b0000; alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b1;

    // Reset held, then released: IDLE, FETCH, DECODE, EXEC_R, ALU_WB_R.
    cyc(0, 4'b0000, 0, 0, 1, v_zero(), "reset0");
    cyc(0, 4'b0000, 0, 0, 1, v_zero(), "reset1");
    cyc(1, 4'b0000, 0, 0, 1, v_zero(), "idle");
    fetch_decode(4'b0000, "r");
    cyc(1, 4'b0000, 0, 0, 1, v_exec_r(4'b0000), "r_exec_r");
    cyc(1, 4'b0000, 0, 0, 1, v_wb_r(), "r_wb_r");

    // lw with one fetch stall and three MEM_RD stalls.
    cyc(1, 4'b0111, 0, 0, 0, v_fetch(0), "lw_fetch_stall");
    fetch_decode(4'b0111, "lw");
    cyc(1, 4'b0111, 0, 0, 1, v_mem_addr(), "lw_mem_addr");
    cyc(1, 4'b0111, 0, 0, 0, v_mem_rd(), "lw_mem_rd_w1");
    cyc(1, 4'b0111, 0, 0, 0, v_mem_rd(), "lw_mem_rd_w2");
    cyc(1, 4'b0111, 0, 0, 0, v_mem_rd(), "lw_mem_rd_w3");
    cyc(1, 4'b0111, 0, 0, 1, v_mem_rd(), "lw_mem_rd_done");
    cyc(1, 4'b0111, 0, 0, 1, v_mem_wb(), "lw_mem_wb");

    // Immediate ALU ops: ALUOp follows the opcode in EXEC_I.
    alu_i(4'b0001, "addi");
    alu_i(4'b0010, "andi");
    alu_i(4'b0011, "ori");
    alu_i(4'b0100, "subi");

    // sw, ready immediately.
    fetch_decode(4'b1000, "sw");
    cyc(1, 4'b1000, 0, 0, 1, v_mem_addr(), "sw_mem_addr");
    cyc(1, 4'b1000, 0, 0, 1, v_mem_wr(), "sw_mem_wr");

    // Branches over (zero,neg) = (1,0), (0,1), (0,0).
    br(4'b1001, 1, 0, 1, "beq_z");   br(4'b1001, 0, 1, 0, "beq_n");   br(4'b1001, 0, 0, 0, "beq_p");
    br(4'b1010, 1, 0, 0, "bne_z");   br(4'b1010, 0, 1, 1, "bne_n");   br(4'b1010, 0, 0, 1, "bne_p");
    br(4'b1011, 1, 0, 0, "blt_z");   br(4'b1011, 0, 1, 1, "blt_n");   br(4'b1011, 0, 0, 0, "blt_p");
    br(4'b1100, 1, 0, 0, "bgt_z");   br(4'b1100, 0, 1, 0, "bgt_n");   br(4'b1100, 0, 0, 1, "bgt_p");

    // Jump.
    fetch_decode(4'b0101, "j");
    cyc(1, 4'b0101, 0, 0, 1, v_jump(), "j_jump");

    // Illegal opcodes squash back to FETCH with a one-cycle pulse.
    cyc(1, 4'b1101, 0, 0, 1, v_fetch(1), "ill1101_fetch");
    cyc(1, 4'b1101, 0, 0, 1, v_decode(1), "ill1101_decode");
    cyc(1, 4'b0110, 0, 0, 1, v_fetch(1), "ill0110_fetch");
    cyc(1, 4'b0110, 0, 0, 1, v_decode(1), "ill0110_decode");

    // sw stalled in MEM_WR, reset asserted mid-cycle: strobes drop before the next edge.
    cyc(1, 4'b1000, 0, 0, 1, v_fetch(1), "swrst_fetch");
    cyc(1, 4'b1000, 0, 0, 1, v_decode(0), "swrst_decode");
    cyc(1, 4'b1000, 0, 0, 0, v_mem_addr(), "swrst_mem_addr");
    cyc(1, 4'b1000, 0, 0, 0, v_mem_wr(), "swrst_mem_wr");
    cyc(0, 4'b1000, 0, 0, 0, v_zero(), "swrst_async_drop");
    cyc(0, 4'b1000, 0, 0, 0, v_zero(), "swrst_held");
    cyc(1, 4'b1000, 0, 0, 1, v_zero(), "swrst_idle");
    cyc(1, 4'b1000, 0, 0, 1, v_fetch(1), "swrst_refetch");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
